xulie_piso_gen: RTL and testbench
=================================

Name: xulie_piso_gen

Overview:
- Parallel-in/serial-out bit-stream generator that sits directly upstream of the 1110 sequence detector.
- Its Dout drives the detector's Din.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per Clk.
- A one-word holding buffer lets consecutive words stream gaplessly, so patterns that straddle word boundaries reach the detector intact.

Parameters:
- WIDTH, 8: bits per parallel word; legal range 2..32.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 0: value driven on Dout when no word is being shifted.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Data_in  input  WIDTH  parallel word to serialise.
- Load_valid  input  1  Data_in is valid this cycle.
- Load_ready  output  1  block can accept a word this cycle.
- Dout  output  1  serial bit stream, to detector Din.
- Dout_valid  output  1  Dout carries a data bit, not idle fill.
- Last  output  1  Dout currently carries the final bit of a word.
- Busy  output  1  shifting in progress, or holding buffer occupied.

Behaviour:
- Registers:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH)
  - holding register hold[WIDTH-1:0] with flag hold_full
  - state, one of IDLE or SHIFT
- Reset (asynchronous, any time including mid-word):
  - state=IDLE, cnt=0, hold_full=0, sh=0.
  - Dout=IDLE_LEVEL, Dout_valid=0, Last=0, Busy=0, Load_ready=1.
  - In-flight and held words are discarded; no partial word completes after reset is released.
- Handshake:
  - Transfer occurs on a rising edge where Load_valid=1 and Load_ready=1.
  - Load_ready = ~hold_full, registered-state-derived; there is no combinational path from Load_valid.
  - Data_in is sampled only on a transfer edge.
- IDLE:
  - Dout=IDLE_LEVEL, Dout_valid=0.
  - On transfer: sh<=Data_in, cnt<=0, state<=SHIFT.
  - First data bit appears on Dout immediately after that edge, giving 1-cycle latency from accept to first bit.
- SHIFT:
  - Dout = sh[WIDTH-1] when MSB_FIRST=1, else sh[0]; Dout_valid=1.
  - Each edge shifts sh by one toward the output end and increments cnt.
  - Last=1 when cnt==WIDTH-1.
  - Each word occupies exactly WIDTH consecutive valid cycles.
- Transfer during SHIFT with cnt<WIDTH-1: hold<=Data_in, hold_full<=1.
- End of word (edge with cnt==WIDTH-1):
  - If hold_full=1: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT. No gap; Dout_valid stays 1.
  - Else if a transfer occurs on this same edge: sh<=Data_in, cnt<=0, stay in SHIFT. This is gapless, and the word bypasses hold.
  - Else: state<=IDLE; Dout returns to IDLE_LEVEL on the next cycle.
- Busy = (state==SHIFT) | hold_full.
- Load_valid deasserted: no effect. A word already in progress always completes; it cannot be aborted except by Reset.
- With hold_full=1, Load_ready=0 until the end-of-word edge that drains hold. A third word therefore waits at most WIDTH cycles.
- Sustained throughput: one word per WIDTH cycles, 100% serial line utilisation.

Test Plan:
1. Reset, then one transfer of Data_in=8'hE0 (MSB_FIRST=1):
   - Dout = 1,1,1,0,0,0,0,0 on the 8 cycles after the accept edge.
   - Dout_valid=1 for exactly 8 cycles; Last=1 only on the 8th.
   - Dout then returns to 0, Busy=0.
2. Back-to-back 8'h07 then 8'h00, the second offered while the first is shifting:
   - Gapless 16-bit stream 0000011100000000 with Dout_valid continuous.
   - Load_ready=0 from the hold-fill edge until the boundary edge.
   - Downstream detector fires once for the 1110 spanning the boundary.
3. Load_valid held high with words A, B, C:
   - A accepted in IDLE; B accepted next cycle into hold.
   - C stalls (Load_ready=0) until A's last-bit edge, then C loads into hold.
   - Output is A, B, C bits contiguous.
4. MSB_FIRST=0, Data_in=8'h0E: Dout = 0,1,1,1,0,0,0,0.
5. Reset asserted asynchronously mid-word, at the 4th bit of 8'hFF:
   - Dout=IDLE_LEVEL, Dout_valid=0, Load_ready=1 immediately, without waiting for a Clk edge.
   - After release, no residual bits appear until a new transfer.
6. Load_valid=0 for 20 cycles after reset: Dout stays IDLE_LEVEL, Dout_valid=0, Busy=0, Load_ready=1 throughout.

Source files
------------

// File: rtl/xulie_piso_gen_if.sv
// Parallel-load / serial-out handshake bundle between a word source and the
// PISO generator feeding the 1110 detector.
interface xulie_piso_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Data_in;
  logic             Load_valid;
  logic             Load_ready;
  logic             Dout;
  logic             Dout_valid;
  logic             Last;
  logic             Busy;

  modport master (
    output Data_in, Load_valid,
    input  Load_ready, Dout, Dout_valid, Last, Busy
  );

  modport slave (
    input  Data_in, Load_valid,
    output Load_ready, Dout, Dout_valid, Last, Busy
  );
endinterface

// File: rtl/xulie_piso_gen.sv
// Parallel-in/serial-out bit-stream generator with a one-word holding buffer so
// back-to-back words stream out with no idle bit between them.
module xulie_piso_gen #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  xulie_piso_gen_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n, hold, hold_n, shifted;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             xfer, at_last;

  assign xfer    = bus.Load_valid & ~hold_full;
  assign at_last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign shifted = (MSB_FIRST != 0) ? (sh << 1) : (sh >> 1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
    end
  end

  always_comb begin
    state_n     = state;
    sh_n        = sh;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          sh_n    = bus.Data_in;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          sh_n  = shifted;
          cnt_n = cnt + CW'(1);
          if (xfer) begin
            hold_n      = bus.Data_in;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          // Held word takes over on the boundary edge; Load_ready was low so no xfer here.
          sh_n        = hold;
          hold_full_n = 1'b0;
          cnt_n       = '0;
        end else if (xfer) begin
          sh_n  = bus.Data_in;
          cnt_n = '0;
        end else begin
          sh_n    = shifted;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.Load_ready = ~hold_full;
  assign bus.Dout       = (state == SHIFT)
                          ? ((MSB_FIRST != 0) ? sh[WIDTH-1] : sh[0])
                          : IDLE_LEVEL;
  assign bus.Dout_valid = (state == SHIFT);
  assign bus.Last       = at_last;
  assign bus.Busy       = (state == SHIFT) | hold_full;
endmodule

// File: tb/tb_xulie_piso_gen.sv
// Bench for xulie_piso_gen: MSB-first and LSB-first instances share stimulus and
// are checked against a bit-queue model of the serial line.
module tb_xulie_piso_gen;
  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  xulie_piso_gen_if #(.WIDTH(W)) b0 ();
  xulie_piso_gen_if #(.WIDTH(W)) b1 ();

  xulie_piso_gen #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(b0));
  xulie_piso_gen #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(b1));

  int nvec = 0;
  int nerr = 0;

  // Model: queued bits in transmit order; front is what Dout must show now.
  bit       q0[$];
  bit       q1[$];
  logic [W-1:0] pend[$];
  logic [31:0] cap0, cap1;
  logic [3:0]  hist0;
  int          det0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_last(int sz);
    return (sz > 0) && (((sz - 1) % W) == 0);
  endfunction

  task automatic chk_line(string tag, bit dout, bit dv, bit last, bit busy, bit rdy, bit q[$]);
    chk({tag, ".dout"},  32'(dout), 32'(q.size() > 0 ? q[0] : 1'b0));
    chk({tag, ".dv"},    32'(dv),   32'(q.size() > 0));
    chk({tag, ".last"},  32'(last), 32'(exp_last(q.size())));
    chk({tag, ".busy"},  32'(busy), 32'(q.size() > 0));
    chk({tag, ".ready"}, 32'(rdy),  32'(q.size() <= W));
  endtask

  // One clock: drive at negedge, check, advance model across the posedge.
  task automatic cyc(input bit gate);
    bit v, x;
    logic [W-1:0] d;
    v = gate && (pend.size() > 0);
    d = (pend.size() > 0) ? pend[0] : '0;
    b0.Load_valid = v; b0.Data_in = d;
    b1.Load_valid = v; b1.Data_in = d;
    #1;
    chk_line("m", b0.Dout, b0.Dout_valid, b0.Last, b0.Busy, b0.Load_ready, q0);
    chk_line("l", b1.Dout, b1.Dout_valid, b1.Last, b1.Busy, b1.Load_ready, q1);
    if (b0.Dout_valid) begin
      cap0  = {cap0[30:0], b0.Dout};
      hist0 = {hist0[2:0], b0.Dout};
      if (hist0 == 4'b1110) det0++;
    end
    if (b1.Dout_valid) cap1 = {cap1[30:0], b1.Dout};
    x = v && (q0.size() <= W);
    @(posedge Clk);
    if (q0.size() > 0) void'(q0.pop_front());
    if (q1.size() > 0) void'(q1.pop_front());
    if (x) begin
      for (int i = W - 1; i >= 0; i--) q0.push_back(d[i]);
      for (int i = 0; i < W; i++)      q1.push_back(d[i]);
      void'(pend.pop_front());
    end
    @(negedge Clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend.size() > 0 || q0.size() > 0) && n < 400) begin
      cyc(1'b1);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 32'(n), 32'd0);
    cyc(1'b1);
    cyc(1'b1);
  endtask

  task automatic clr_cap();
    cap0 = '0; cap1 = '0; hist0 = '0; det0 = 0;
  endtask

  initial begin
    b0.Load_valid = 1'b0; b0.Data_in = '0;
    b1.Load_valid = 1'b0; b1.Data_in = '0;
    clr_cap();
    #2;
    chk("rst.dout",  32'(b0.Dout), 32'd0);
    chk("rst.dv",    32'(b0.Dout_valid), 32'd0);
    chk("rst.ready", 32'(b0.Load_ready), 32'd1);
    chk("rst.busy",  32'(b0.Busy), 32'd0);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;

    // Idle line with no offered words.
    for (int i = 0; i < 20; i++) cyc(1'b0);

    // Single E0 word.
    clr_cap();
    pend.push_back(8'hE0);
    drain();
    chk("e0.msb_bits", cap0, 32'h0000_00E0);
    chk("e0.lsb_bits", cap1, 32'h0000_0007);

    // 07 then 00 back to back: 1110 straddles the boundary.
    clr_cap();
    pend.push_back(8'h07); pend.push_back(8'h00);
    drain();
    chk("b2b.bits", cap0, 32'h0000_0700);
    chk("b2b.detect", 32'(det0), 32'd1);

    // Three words with valid held high; third stalls behind the hold buffer.
    clr_cap();
    pend.push_back(8'hA5); pend.push_back(8'h3C); pend.push_back(8'hC3);
    drain();
    chk("abc.bits", cap0, 32'h00A5_3CC3);

    // LSB-first instance with 0E.
    clr_cap();
    pend.push_back(8'h0E);
    drain();
    chk("0e.lsb_bits", cap1, 32'h0000_0070);
    chk("0e.msb_bits", cap0, 32'h0000_000E);

    // Asynchronous reset during the 4th bit of FF.
    pend.push_back(8'hFF);
    for (int i = 0; i < 4; i++) cyc(1'b1);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst.dout",  32'(b0.Dout), 32'd0);
    chk("arst.dv",    32'(b0.Dout_valid), 32'd0);
    chk("arst.ready", 32'(b0.Load_ready), 32'd1);
    chk("arst.busy",  32'(b0.Busy), 32'd0);
    q0.delete(); q1.delete(); pend.delete();
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1'b0);

    // Random words with random valid gaps.
    for (int i = 0; i < 400; i++) begin
      if (pend.size() < 3 && $urandom_range(2) == 0) pend.push_back(W'($urandom));
      cyc($urandom_range(3) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
